// File: rtl/cpx_issue_queue.sv
// Issue queue for the complex-arithmetic execute stage. It buffers instructions, holds
// each one on the operand bus through divider stalls, and retires it with its tag.
module cpx_issue_queue #(
    parameter int         DATA_SIZE      = 8,
    parameter int         DEPTH          = 4,
    parameter int         TAG_W          = 4,
    parameter logic [3:0] DIV_OP         = 4'b0011,
    parameter logic [3:0] NOP_OP         = 4'b0000,
    parameter int         MAX_DIV_CYCLES = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3:0]                  in_op,
    input  logic signed [DATA_SIZE-1:0] in_a1,
    input  logic signed [DATA_SIZE-1:0] in_a2,
    input  logic signed [DATA_SIZE-1:0] in_b1,
    input  logic signed [DATA_SIZE-1:0] in_b2,
    input  logic [TAG_W-1:0]            in_tag,
    output logic [3:0]                  Op,
    output logic signed [DATA_SIZE-1:0] A1,
    output logic signed [DATA_SIZE-1:0] A2,
    output logic signed [DATA_SIZE-1:0] B1,
    output logic signed [DATA_SIZE-1:0] B2,
    input  logic                        Stall,
    input  logic signed [DATA_SIZE-1:0] ex_out1,
    input  logic signed [DATA_SIZE-1:0] ex_out2,
    output logic                        ret_valid,
    output logic [TAG_W-1:0]            ret_tag,
    output logic signed [DATA_SIZE-1:0] ret_out1,
    output logic signed [DATA_SIZE-1:0] ret_out2,
    output logic                        ret_err,
    output logic                        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_DIV_CYCLES + 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_DIV_CYCLES);

    typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_EXEC, S_DIV_WAIT} state_t;

    typedef struct packed {
        logic [3:0]                  op;
        logic signed [DATA_SIZE-1:0] a1;
        logic signed [DATA_SIZE-1:0] a2;
        logic signed [DATA_SIZE-1:0] b1;
        logic signed [DATA_SIZE-1:0] b2;
        logic [TAG_W-1:0]            tag;
    } entry_t;

    state_t                      r_state, w_state_nx;
    logic [CW-1:0]               r_cnt, w_cnt_nx;
    entry_t                      r_mem [DEPTH];
    logic [AW-1:0]               r_wr, r_rd;
    logic [AW:0]                 r_count;

    entry_t                      w_in, w_head, w_next, w_sel;
    logic                        w_push, w_pop, w_full;
    logic                        w_head_avail, w_next_avail;
    logic                        w_load, w_use_next, w_drive_nop, w_drive_flush;
    logic                        w_retire, w_err, w_complete;

    logic [3:0]                  r_op;
    logic signed [DATA_SIZE-1:0] r_a1, r_a2, r_b1, r_b2;
    logic [TAG_W-1:0]            r_cur_tag;
    logic                        r_ret_valid, r_ret_err;
    logic [TAG_W-1:0]            r_ret_tag;
    logic signed [DATA_SIZE-1:0] r_ret_out1, r_ret_out2;

    assign w_full   = (r_count == FULL_CNT);
    assign in_ready = (r_state != S_FLUSH) && !w_full;
    assign w_push   = in_valid && in_ready;
    assign busy     = (r_state != S_IDLE) || (r_count != '0);

    assign w_in = '{op: in_op, a1: in_a1, a2: in_a2, b1: in_b1, b2: in_b2, tag: in_tag};

    // An empty queue forwards the incoming instruction so issue costs only one cycle.
    assign w_head       = (r_count == '0) ? w_in : r_mem[r_rd];
    assign w_head_avail = (r_count != '0) || w_push;
    assign w_next       = (r_count > (AW+1)'(1)) ? r_mem[r_rd + AW'(1)] : w_in;
    assign w_next_avail = (r_count > (AW+1)'(1)) || w_push;
    assign w_sel        = w_use_next ? w_next : w_head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FLUSH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_load        = 1'b0;
        w_use_next    = 1'b0;
        w_drive_nop   = 1'b0;
        w_drive_flush = 1'b0;
        w_retire      = 1'b0;
        w_err         = 1'b0;
        w_pop         = 1'b0;
        w_complete    = 1'b0;
        case (r_state)
            S_FLUSH: begin
                // r_cnt == 0 with DIV on the bus marks the launch cycle, where Stall is ignored.
                if (r_op != DIV_OP) begin
                    w_drive_flush = 1'b1;
                    w_cnt_nx      = '0;
                end else if (r_cnt == '0) begin
                    w_cnt_nx = CW'(1);
                end else if (!Stall || r_cnt == MAX_CNT) begin
                    w_state_nx  = S_IDLE;
                    w_drive_nop = 1'b1;
                    w_cnt_nx    = '0;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            S_IDLE: begin
                if (w_head_avail) begin
                    w_load     = 1'b1;
                    w_cnt_nx   = '0;
                    w_state_nx = (w_head.op == DIV_OP) ? S_DIV_WAIT : S_EXEC;
                end
            end
            S_EXEC: begin
                w_complete = 1'b1;
            end
            S_DIV_WAIT: begin
                if (r_cnt == '0) begin
                    w_cnt_nx = CW'(1);
                end else if (!Stall) begin
                    w_complete = 1'b1;
                end else if (r_cnt == MAX_CNT) begin
                    w_pop         = 1'b1;
                    w_retire      = 1'b1;
                    w_err         = 1'b1;
                    w_drive_flush = 1'b1;
                    w_cnt_nx      = '0;
                    w_state_nx    = S_FLUSH;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nx = S_FLUSH;
            end
        endcase

        if (w_complete) begin
            w_pop    = 1'b1;
            w_retire = 1'b1;
            if (w_next_avail) begin
                w_load     = 1'b1;
                w_use_next = 1'b1;
                w_cnt_nx   = '0;
                w_state_nx = (w_next.op == DIV_OP) ? S_DIV_WAIT : S_EXEC;
            end else begin
                w_drive_nop = 1'b1;
                w_state_nx  = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= w_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op      <= NOP_OP;
            r_a1      <= '0;
            r_a2      <= '0;
            r_b1      <= '0;
            r_b2      <= '0;
            r_cur_tag <= '0;
        end else if (w_load) begin
            r_op      <= w_sel.op;
            r_a1      <= w_sel.a1;
            r_a2      <= w_sel.a2;
            r_b1      <= w_sel.b1;
            r_b2      <= w_sel.b2;
            r_cur_tag <= w_sel.tag;
        end else if (w_drive_nop || w_drive_flush) begin
            r_op <= w_drive_flush ? DIV_OP : NOP_OP;
            r_a1 <= '0;
            r_a2 <= '0;
            r_b1 <= '0;
            r_b2 <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ret_valid <= 1'b0;
            r_ret_tag   <= '0;
            r_ret_out1  <= '0;
            r_ret_out2  <= '0;
            r_ret_err   <= 1'b0;
        end else begin
            r_ret_valid <= w_retire;
            if (w_retire) begin
                r_ret_tag  <= r_cur_tag;
                r_ret_err  <= w_err;
                r_ret_out1 <= w_err ? '0 : ex_out1;
                r_ret_out2 <= w_err ? '0 : ex_out2;
            end
        end
    end

    assign Op        = r_op;
    assign A1        = r_a1;
    assign A2        = r_a2;
    assign B1        = r_b1;
    assign B2        = r_b2;
    assign ret_valid = r_ret_valid;
    assign ret_tag   = r_ret_tag;
    assign ret_out1  = r_ret_out1;
    assign ret_out2  = r_ret_out2;
    assign ret_err   = r_ret_err;

endmodule

// File: tb/tb_cpx_issue_queue.sv
// Directed bench for cpx_issue_queue: flush, single issue, divider hold, full queue,
// watchdog timeout and mid-operation reset.
module tb_cpx_issue_queue;
    logic              clk = 1'b0;
    logic              rst_n, in_valid, in_ready, Stall;
    logic [3:0]        in_op, in_tag, Op, ret_tag;
    logic signed [7:0] in_a1, in_a2, in_b1, in_b2;
    logic signed [7:0] A1, A2, B1, B2, ex_out1, ex_out2, ret_out1, ret_out2;
    logic              ret_valid, ret_err, busy;

    int n_pass  = 0;
    int n_total = 0;

    cpx_issue_queue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a1(in_a1), .in_a2(in_a2), .in_b1(in_b1), .in_b2(in_b2),
        .in_tag(in_tag), .Op(Op), .A1(A1), .A2(A2), .B1(B1), .B2(B2),
        .Stall(Stall), .ex_out1(ex_out1), .ex_out2(ex_out2),
        .ret_valid(ret_valid), .ret_tag(ret_tag), .ret_out1(ret_out1),
        .ret_out2(ret_out2), .ret_err(ret_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] tag,
                         input int a1, input int a2, input int b1, input int b2);
        in_valid = v;
        in_op    = op;
        in_tag   = tag;
        in_a1    = 8'(a1);
        in_a2    = 8'(a2);
        in_b1    = 8'(b1);
        in_b2    = 8'(b2);
    endtask

    initial begin
        rst_n = 1'b0;
        Stall = 1'b0;
        ex_out1 = '0;
        ex_out2 = '0;
        drive(1'b0, 4'd0, 4'd0, 0, 0, 0, 0);

        // Reset state
        nedge();
        chk("rst_op", Op, 4'b0000);
        chk("rst_a1", A1, 0);
        chk("rst_b2", B2, 0);
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_ret_tag", ret_tag, 0);
        chk("rst_ret_out1", ret_out1, 0);
        chk("rst_ret_err", ret_err, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 1);
        nedge();
        rst_n = 1'b1;

        // Flush: DIV for launch + 2 stalls + completion
        for (int k = 0; k < 4; k++) begin
            nedge();
            chk("flush_op", Op, 4'b0011);
            chk("flush_in_ready", in_ready, 0);
            chk("flush_ret_valid", ret_valid, 0);
            Stall = (k < 3);
        end
        nedge();
        chk("flush_done_op", Op, 4'b0000);
        chk("flush_done_in_ready", in_ready, 1);
        chk("flush_done_busy", busy, 0);
        chk("flush_done_ret_valid", ret_valid, 0);

        // Single ADD into idle queue
        drive(1'b1, 4'b0001, 4'd2, 10, 20, 30, 40);
        ex_out1 = 8'sd5;
        ex_out2 = -8'sd3;
        nedge();
        drive(1'b0, 4'd0, 4'd0, 0, 0, 0, 0);
        chk("add_op", Op, 4'b0001);
        chk("add_a1", A1, 10);
        chk("add_b2", B2, 40);
        chk("add_no_ret_yet", ret_valid, 0);
        nedge();
        chk("add_ret_valid", ret_valid, 1);
        chk("add_ret_tag", ret_tag, 2);
        chk("add_ret_out1", ret_out1, 5);
        chk("add_ret_out2", ret_out2, -3);
        chk("add_ret_err", ret_err, 0);
        chk("add_op_idle", Op, 4'b0000);
        nedge();
        chk("add_ret_pulse", ret_valid, 0);
        chk("add_busy", busy, 0);

        // DIV tag 1 then MUL tag 3
        drive(1'b1, 4'b0011, 4'd1, 1, 2, 3, 4);
        Stall = 1'b0;
        nedge();
        chk("div_launch_op", Op, 4'b0011);
        drive(1'b1, 4'b0010, 4'd3, 5, 6, 7, 8);
        for (int k = 0; k < 9; k++) begin
            nedge();
            drive(1'b0, 4'd0, 4'd0, 0, 0, 0, 0);
            chk("div_hold_op", Op, 4'b0011);
            chk("div_hold_a1", A1, 1);
            chk("div_hold_b2", B2, 4);
            chk("div_hold_no_ret", ret_valid, 0);
            Stall = (k < 8);
        end
        ex_out1 = 8'sd2;
        ex_out2 = -8'sd1;
        nedge();
        chk("div_ret_valid", ret_valid, 1);
        chk("div_ret_tag", ret_tag, 1);
        chk("div_ret_out1", ret_out1, 2);
        chk("div_ret_out2", ret_out2, -1);
        chk("div_ret_err", ret_err, 0);
        chk("mul_op", Op, 4'b0010);
        chk("mul_a1", A1, 5);
        ex_out1 = 8'sd9;
        ex_out2 = -8'sd9;
        nedge();
        chk("mul_ret_valid", ret_valid, 1);
        chk("mul_ret_tag", ret_tag, 3);
        chk("mul_ret_out2", ret_out2, -9);
        chk("mul_op_idle", Op, 4'b0000);

        // Fill queue while DIV is stalled
        drive(1'b1, 4'b0011, 4'd4, 1, 1, 1, 1);
        nedge();
        chk("fill_rdy0", in_ready, 1);
        drive(1'b1, 4'b0001, 4'd5, 2, 2, 2, 2);
        Stall = 1'b1;
        nedge();
        chk("fill_rdy1", in_ready, 1);
        drive(1'b1, 4'b0010, 4'd6, 3, 3, 3, 3);
        nedge();
        chk("fill_rdy2", in_ready, 1);
        drive(1'b1, 4'b0001, 4'd9, 4, 4, 4, 4);
        nedge();
        chk("fill_full", in_ready, 0);
        drive(1'b1, 4'b0001, 4'd10, 5, 5, 5, 5);
        nedge();
        chk("fill_full_compl", in_ready, 0);
        Stall = 1'b0;
        ex_out1 = 8'sd3;
        ex_out2 = 8'sd4;
        nedge();
        drive(1'b0, 4'd0, 4'd0, 0, 0, 0, 0);
        chk("fill_rdy_after", in_ready, 1);
        chk("fill_ret_tag4", ret_tag, 4);
        chk("fill_ret4_out1", ret_out1, 3);
        chk("fill_next_op", Op, 4'b0001);
        ex_out1 = 8'sd11;
        ex_out2 = 8'sd12;
        nedge();
        chk("fill_ret_tag5", ret_tag, 5);
        chk("fill_ret5_out2", ret_out2, 12);
        ex_out1 = 8'sd13;
        ex_out2 = 8'sd14;
        nedge();
        chk("fill_ret_tag6", ret_tag, 6);
        chk("fill_ret6_valid", ret_valid, 1);
        ex_out1 = 8'sd15;
        ex_out2 = 8'sd16;
        nedge();
        chk("fill_ret_tag9", ret_tag, 9);
        chk("fill_ret9_out1", ret_out1, 15);
        chk("fill_idle_op", Op, 4'b0000);

        // Watchdog timeout on DIV tag 7
        drive(1'b1, 4'b0011, 4'd7, 1, 2, 3, 4);
        Stall = 1'b1;
        ex_out1 = 8'sd7;
        ex_out2 = 8'sd7;
        nedge();
        drive(1'b0, 4'd0, 4'd0, 0, 0, 0, 0);
        chk("wd_launch_op", Op, 4'b0011);
        for (int k = 0; k < 15; k++) begin
            nedge();
            chk("wd_wait_no_ret", ret_valid, 0);
            chk("wd_wait_a1", A1, 1);
        end
        nedge();
        chk("wd_ret_valid", ret_valid, 1);
        chk("wd_ret_err", ret_err, 1);
        chk("wd_ret_tag", ret_tag, 7);
        chk("wd_ret_out1", ret_out1, 0);
        chk("wd_ret_out2", ret_out2, 0);
        chk("wd_flush_op", Op, 4'b0011);
        chk("wd_flush_a1", A1, 0);
        chk("wd_flush_rdy", in_ready, 0);
        Stall = 1'b0;
        nedge();
        chk("wd_flush2_rdy", in_ready, 0);
        chk("wd_flush2_busy", busy, 1);
        nedge();
        chk("wd_idle_op", Op, 4'b0000);
        chk("wd_idle_rdy", in_ready, 1);

        // Reset mid-DIV with entries queued
        drive(1'b1, 4'b0011, 4'd8, 1, 1, 1, 1);
        Stall = 1'b1;
        nedge();
        drive(1'b1, 4'b0001, 4'd9, 2, 2, 2, 2);
        nedge();
        drive(1'b1, 4'b0001, 4'd10, 3, 3, 3, 3);
        nedge();
        drive(1'b0, 4'd0, 4'd0, 0, 0, 0, 0);
        rst_n = 1'b0;
        nedge();
        chk("mrst_op", Op, 4'b0000);
        chk("mrst_no_ret", ret_valid, 0);
        chk("mrst_rdy", in_ready, 0);
        chk("mrst_busy", busy, 1);
        rst_n = 1'b1;
        Stall = 1'b0;
        nedge();
        chk("mrst_flush_op", Op, 4'b0011);
        chk("mrst_flush_no_ret", ret_valid, 0);
        nedge();
        chk("mrst_flush_op2", Op, 4'b0011);
        nedge();
        chk("mrst_idle_op", Op, 4'b0000);
        chk("mrst_empty_busy", busy, 0);
        chk("mrst_idle_no_ret", ret_valid, 0);

        drive(1'b1, 4'b0011, 4'd11, 9, 8, 7, 6);
        nedge();
        drive(1'b0, 4'd0, 4'd0, 0, 0, 0, 0);
        chk("post_div_op", Op, 4'b0011);
        chk("post_div_a1", A1, 9);
        Stall = 1'b1;
        nedge();
        nedge();
        Stall = 1'b0;
        ex_out1 = -8'sd4;
        ex_out2 = 8'sd6;
        nedge();
        chk("post_ret_valid", ret_valid, 1);
        chk("post_ret_tag", ret_tag, 11);
        chk("post_ret_out1", ret_out1, -4);
        chk("post_ret_out2", ret_out2, 6);
        chk("post_ret_err", ret_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
